// File: rtl/pe_cfg_loader.sv
// Configuration loader for one CGRA processing element: validates 3-word
// frames from the config chain and atomically commits ALU/reg_unit select bits.
module pe_cfg_loader #(
  parameter logic [7:0] PE_ID    = 8'h00,
  parameter logic [7:0] MAGIC    = 8'hA5,
  parameter logic [7:0] BCAST_ID = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [31:0] cfg_data,
  input  logic        cfg_abort,
  output logic [2:0]  alu_func,
  output logic        tide_en,
  output logic        tide_rst,
  output logic        cfg_busy,
  output logic        cfg_done,
  output logic        cfg_err
);

  localparam int unsigned DW = 32;
  localparam int unsigned FW = 3;

  typedef enum logic [2:0] {HDR, PAY, CHK, SKIP1, SKIP2, COMMIT} state_t;

  state_t          state, state_next;
  logic [DW-1:0]   w0_q, w1_q;
  logic            accept_c;
  logic            hdr_ok_c, id_ok_c, frame_bad_c;
  logic            load_w0_c, load_w1_c, clear_c, commit_c, err_c;

  assign accept_c = cfg_valid && cfg_ready;

  // Frame field decode; checksum covers the latched header and payload.
  always_comb begin
    hdr_ok_c    = 1'b0;
    id_ok_c     = 1'b0;
    frame_bad_c = 1'b0;
    hdr_ok_c    = (cfg_data[31:24] == MAGIC);
    id_ok_c     = (cfg_data[23:16] == PE_ID) || (cfg_data[23:16] == BCAST_ID);
    frame_bad_c = (cfg_data != (w0_q ^ w1_q))
               || (w1_q[31:5] != 27'd0)
               || (w1_q[FW-1:0] > 3'd5)
               || (w0_q[15:0] != 16'd0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= HDR;
    else      state <= state_next;
  end

  // Next state and datapath strobes; abort overrides any transfer.
  always_comb begin
    state_next = state;
    load_w0_c  = 1'b0;
    load_w1_c  = 1'b0;
    clear_c    = 1'b0;
    commit_c   = 1'b0;
    err_c      = 1'b0;
    case (state)
      HDR: begin
        if (accept_c && hdr_ok_c) begin
          if (id_ok_c) begin
            load_w0_c  = 1'b1;
            state_next = PAY;
          end else begin
            state_next = SKIP1;
          end
        end
      end
      PAY: begin
        if (accept_c) begin
          load_w1_c  = 1'b1;
          state_next = CHK;
        end
      end
      CHK: begin
        if (accept_c) begin
          if (frame_bad_c) begin
            err_c      = 1'b1;
            state_next = HDR;
          end else begin
            state_next = COMMIT;
          end
        end
      end
      SKIP1:   if (accept_c) state_next = SKIP2;
      SKIP2:   if (accept_c) state_next = HDR;
      COMMIT: begin
        commit_c   = 1'b1;
        state_next = HDR;
      end
      default: state_next = HDR;
    endcase
    if (cfg_abort) begin
      state_next = HDR;
      load_w0_c  = 1'b0;
      load_w1_c  = 1'b0;
      err_c      = 1'b0;
      clear_c    = 1'b1;
    end
  end

  // Shadow registers, committed outputs and status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w0_q      <= '0;
      w1_q      <= '0;
      alu_func  <= '0;
      tide_en   <= 1'b0;
      tide_rst  <= 1'b0;
      cfg_ready <= 1'b0;
      cfg_busy  <= 1'b0;
      cfg_done  <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      cfg_ready <= (state_next != COMMIT);
      cfg_busy  <= (state_next != HDR);
      cfg_done  <= commit_c;
      cfg_err   <= err_c;
      if (clear_c) begin
        w0_q <= '0;
        w1_q <= '0;
      end else begin
        if (load_w0_c) w0_q <= cfg_data;
        if (load_w1_c) w1_q <= cfg_data;
      end
      if (commit_c) begin
        alu_func <= w1_q[FW-1:0];
        tide_en  <= w1_q[3];
        tide_rst <= w1_q[4];
      end
    end
  end

endmodule

// File: doc/pe_cfg_loader.md
Name: pe_cfg_loader

Overview:
- Receives the configuration word stream for one CGRA processing element and produces the static select bits that the mapped cells consume: the ALU function code (0–5) and the reg_unit tide_en/tide_rst bits.
- It is the writer side of those parameters. Techmapping fixes them at compile time; this block delivers them at configuration load time.
- It sits between the fabric config chain and the PE. It validates each frame and commits the new values atomically.

Parameters:
- PE_ID, 8'h00, this PE's target identifier
- MAGIC, 8'hA5, required header tag
- BCAST_ID, 8'hFF, target ID accepted by every PE

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- cfg_valid  in  1  upstream word valid
- cfg_ready  out  1  loader can accept a word
- cfg_data  in  32  config word
- cfg_abort  in  1  synchronous abort, discards the in-flight frame
- alu_func  out  3  committed ALU function code
- tide_en  out  1  committed reg_unit enable-tie bit
- tide_rst  out  1  committed reg_unit reset-tie bit
- cfg_busy  out  1  a frame is in progress (state other than HDR)
- cfg_done  out  1  one-cycle pulse on successful commit
- cfg_err  out  1  one-cycle pulse on a rejected frame

Behaviour:
- Reset: clk and rst are the only clock/reset; rst is asynchronous, active-low.
  - Asserting rst sets alu_func=0, tide_en=0, tide_rst=0, cfg_done=0, cfg_err=0, cfg_ready=0, shadow registers to 0, state=HDR.
  - cfg_ready is registered and rises on the first clk edge after rst deasserts.
- Transfer: a word transfers on a rising edge where cfg_valid && cfg_ready are both high. Nothing else advances the FSM except cfg_abort.
- Frame format, 3 words:
  - W0 header: [31:24]=MAGIC, [23:16]=target ID, [15:0]=0.
  - W1 payload: [2:0]=alu_func, [3]=tide_en, [4]=tide_rst, [31:5]=0.
  - W2 checksum: must equal W0 ^ W1.
- FSM states: HDR, PAY, CHK, SKIP1, SKIP2, COMMIT.
  - HDR on accept:
    - W0[31:24]!=MAGIC: stay in HDR, no error (resync: non-header words are silently dropped).
    - Magic ok and ID is PE_ID or BCAST_ID: latch W0, go to PAY.
    - Magic ok, ID foreign: go to SKIP1 (no error).
  - PAY on accept: latch W1 into shadow, go to CHK.
  - CHK on accept: the frame is bad if any of these hold:
    - checksum mismatch;
    - W1[31:5]!=0;
    - W1[2:0] in {6,7};
    - W0[15:0]!=0.
    - Bad frame: pulse cfg_err next cycle, go to HDR, outputs unchanged.
    - Good frame: go to COMMIT.
  - COMMIT: one cycle with cfg_ready=0. alu_func/tide_en/tide_rst load from shadow at the end of this cycle. cfg_done pulses in the cycle the new values first appear. Return to HDR.
    - Latency is 2 edges from the W2 accept edge to the new outputs being visible.
  - SKIP1 → SKIP2 → HDR: each advance consumes one accepted word. Contents are ignored, no checks.
- cfg_ready: 1 in HDR, PAY, CHK, SKIP1, SKIP2; 0 in COMMIT and during reset.
- cfg_busy: 1 in any state other than HDR.
- cfg_abort:
  - Highest priority. On a sampled-high edge, go to HDR and clear the shadow.
  - Any word transferred on that same edge is discarded.
  - Outputs are unchanged, no cfg_err, no cfg_done.
  - If abort coincides with COMMIT, the commit still completes (outputs update, cfg_done pulses); the FSM then goes to HDR.
- Back-to-back frames: a new W0 may transfer on the first edge after COMMIT with no bubble. Throughput is 4 cycles per frame.
- cfg_done and cfg_err are never high together. Each is high for exactly one cycle per frame.
- Reset mid-frame: everything returns to reset values, including the committed outputs.
- No combinational path from cfg_data to any output.

Test Plan:
- Basic load: PE_ID=8'h03, rst released; send 32'hA5030000, 32'h00000014, 32'hA5030014 with cfg_valid held high → cfg_ready rises 1 cycle after reset; outputs become alu_func=4, tide_en=0, tide_rst=1 with cfg_done=1, 2 edges after the W2 accept; cfg_busy drops.
- Broadcast then foreign ID: send a broadcast frame (ID 8'hFF) setting alu_func=2, then a frame with ID 8'h07 carrying alu_func=5 → first frame commits (alu_func=2); second is skipped, alu_func stays 2, no cfg_err.
- Bad checksum: W2=32'hA5030015 → cfg_err pulses 1 cycle; outputs hold their previous values; the next valid frame commits normally.
- Illegal code: W1=32'h00000006 with a correct checksum → cfg_err; alu_func unchanged.
- Resync: send 32'h12345678 then a valid frame → first word dropped silently, frame commits.
- Abort and stall:
  - cfg_abort after W1 → no pulse, state HDR, outputs unchanged.
  - Toggling cfg_valid randomly during a valid frame → same final outputs as the unstalled frame.
  - Async rst asserted mid-PAY → all outputs 0 immediately.
